mito_conv_engine: RTL
=====================

Name: mito_conv_engine

Overview:
Parametrised convolution engine. Successor to the fixed 3x3, 9-PE accelerator top. Adds an internal control FSM, weight preload for up to CH_MAX input channels, and multi-channel accumulation. Also adds bias add, rounding requantisation, optional ReLU and saturation, with valid/ready streaming on both the input and output sides. It sits between the IFM/WGT stream sources and the OFM buffer.

Parameters:
DATA_W, 8, signed width of IFM, weight, bias and OFM elements
K, 3, kernel side; each beat carries K*K elements
CH_MAX, 16, maximum input channels per window (weight bank depth)
ACC_W, 24, signed accumulator width
CH_W, 5, width of cfg_num_ch (holds values 0..CH_MAX)
WIN_W, 16, width of cfg_num_win

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  job start pulse, honoured only in IDLE
cfg_num_ch  input  CH_W  input channels per window, 1..CH_MAX
cfg_num_win  input  WIN_W  output windows in this job
cfg_bias  input  DATA_W  signed bias
cfg_shift  input  5  requant right shift, 0..ACC_W-1
cfg_relu_en  input  1  1 = clamp negatives to 0
wgt_valid  input  1  weight beat valid
wgt_data  input  K*K*DATA_W  one channel's kernel, element 0 in LSBs
wgt_ready  output  1  weight beat accepted when valid&ready
ifm_valid  input  1  IFM beat valid
ifm_data  input  K*K*DATA_W  one channel's window, element order matches wgt_data
ifm_ready  output  1  IFM beat accepted when valid&ready
ofm_valid  output  1  result valid
ofm_data  output  DATA_W  signed result
ofm_ready  input  1  downstream accept
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at job end

Behaviour:
- Reset: FSM to IDLE. wgt_ready, ifm_ready, ofm_valid, busy and done are 0; ofm_data is 0. Counters, accumulator and pipeline valids are cleared. The weight bank is not cleared. Reset mid-job abandons the job.
- Config sampling: config is sampled into registers on start in IDLE. Later config changes do not affect the running job. start outside IDLE is ignored.
- Zero counts: start with cfg_num_ch==0, cfg_num_ch>CH_MAX or cfg_num_win==0 is ignored; the FSM stays in IDLE and done is not pulsed.
- IDLE -> LOAD_WGT on an honoured start.
- LOAD_WGT: wgt_ready=1. Beat n is stored to bank[n]. After beat cfg_num_ch-1 is accepted, go to COMPUTE. wgt_ready=0 in all other states.
- COMPUTE, input side: ifm_ready = 1 unless drain_pending is set. A channel counter increments on each accepted beat.
- COMPUTE, last beat: on the beat where the channel counter equals cfg_num_ch-1, the counter wraps to 0 and drain_pending is set.
- COMPUTE, stage 1 (edge after the beat): psum = sum over K*K of ifm[i]*bank[ch][i]. Products are signed 2*DATA_W, sign-extended to ACC_W, then registered.
- COMPUTE, stage 2: acc = (first channel ? 0 : acc) + psum.
- COMPUTE, stage 3 (finalise): r = acc + sign-extended bias.
- Rounding: if shift>0, r = (r + (1<<(shift-1))) >>> shift (arithmetic, round half up); if shift==0, r is unchanged.
- ReLU: if relu_en and r<0, r=0.
- Saturation: r is saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Output load: r loads into ofm_data with ofm_valid=1 only when the output register is free (ofm_valid==0 or ofm_ready==1). Otherwise stage 3 holds. drain_pending clears on load.
- Latency: ofm_valid rises 3 cycles after the last-channel beat handshake edge when the output register is free.
- Output hold: ofm_data and ofm_valid stay stable while ofm_valid && !ofm_ready. Only one window is in flight past the last beat.
- Window counter: increments on each output handshake. When the handshake is for window cfg_num_win-1, go to DONE.
- DONE: done=1 for one cycle, then IDLE. The weight bank is retained; a new job reloads it.
- Simultaneous output handshake and new load in the same cycle is legal and gives back-to-back results.

Test Plan:
- Basic window: K=3, ch=1, win=1, weights all 1, ifm all 2, bias 3, shift 0, relu off -> ofm_data=21 three cycles after the ifm beat; done one cycle after the output handshake; busy falls with done.
- Multi-channel: ch=4, weights all 1, channel c ifm all c+1, bias -10 -> ofm_data=80. Check ifm_ready=0 from the last-beat edge until the output load.
- ReLU/rounding: weights all -1, ifm all 10, bias 0, shift 0 -> 0 with relu on, -90 with relu off. Accumulated value 5 with shift 1 -> 3; -5 with shift 1 -> -2.
- Saturation: weights 127, ifm 127, ch=1, shift 4 -> ofm_data=127. Weights -128, ifm 127, shift 0 -> ofm_data=-128.
- Backpressure: win=3, hold ofm_ready=0 for 10 cycles on window 0 -> ofm_data stable, window 1 stalls in stage 3, no result lost. Release -> values 0,1,2 come out in order, then done.
- Illegal/abort: start with ch=0 -> stays IDLE. start while busy -> ignored. rst_n low mid-COMPUTE -> all outputs 0 immediately; the next job runs correctly.

Source files
------------

// File: rtl/mito_conv_engine.sv
// mito_conv_engine: KxK multi-channel convolution engine with weight preload,
// bias, rounding requantisation, optional ReLU, saturation and valid/ready streams.
module mito_conv_engine #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int CH_MAX = 16,
  parameter int ACC_W  = 24,
  parameter int CH_W   = 5,
  parameter int WIN_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CH_W-1:0]           cfg_num_ch,
  input  logic [WIN_W-1:0]          cfg_num_win,
  input  logic [DATA_W-1:0]         cfg_bias,
  input  logic [4:0]                cfg_shift,
  input  logic                      cfg_relu_en,
  input  logic                      wgt_valid,
  input  logic [K*K*DATA_W-1:0]     wgt_data,
  output logic                      wgt_ready,
  input  logic                      ifm_valid,
  input  logic [K*K*DATA_W-1:0]     ifm_data,
  output logic                      ifm_ready,
  output logic                      ofm_valid,
  output logic [DATA_W-1:0]         ofm_data,
  input  logic                      ofm_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int NE    = K * K;
  localparam int BW    = NE * DATA_W;
  localparam int PW    = 2 * DATA_W;
  localparam int IDX_W = (CH_MAX > 1) ? $clog2(CH_MAX) : 1;
  localparam int RW    = ACC_W + 2;
  localparam logic signed [RW-1:0] SMAX = RW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [RW-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMP,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CH_W-1:0]  num_ch_q, num_ch_d;
  logic [WIN_W-1:0] num_win_q, num_win_d;
  logic [DATA_W-1:0] bias_q, bias_d;
  logic [4:0]       shift_q, shift_d;
  logic             relu_q, relu_d;

  logic [CH_W-1:0]  wgt_cnt_q, wgt_cnt_d;
  logic [CH_W-1:0]  ch_cnt_q, ch_cnt_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic             drain_q, drain_d;

  logic             in_vld_q, in_vld_d;
  logic [BW-1:0]    in_data_q, in_data_d;
  logic [IDX_W-1:0] in_ch_q, in_ch_d;
  logic             in_last_q, in_last_d;

  logic             s1_vld_q, s1_vld_d;
  logic             s1_first_q, s1_first_d;
  logic             s1_last_q, s1_last_d;
  logic signed [ACC_W-1:0] psum_q, psum_d;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic             fin_q, fin_d;

  logic             ofm_vld_q, ofm_vld_d;
  logic [DATA_W-1:0] ofm_q, ofm_d;

  logic [BW-1:0]    wgt_bank [CH_MAX];

  logic [CH_W-1:0]  ch_m1;
  logic [WIN_W-1:0] win_m1;
  logic             cfg_ok;
  logic             wgt_fire;
  logic             ifm_fire;
  logic             ofm_fire;
  logic             ofm_load;
  logic             ch_last;

  assign ch_m1     = num_ch_q - 1'b1;
  assign win_m1    = num_win_q - 1'b1;
  assign cfg_ok    = (cfg_num_ch != '0) &&
                     (cfg_num_ch <= CH_W'(CH_MAX)) &&
                     (cfg_num_win != '0);
  assign wgt_ready = (state_q == S_LOAD);
  assign ifm_ready = (state_q == S_COMP) && !drain_q;
  assign wgt_fire  = wgt_valid && wgt_ready;
  assign ifm_fire  = ifm_valid && ifm_ready;
  assign ofm_fire  = ofm_vld_q && ofm_ready;
  assign ofm_load  = fin_q && (!ofm_vld_q || ofm_ready);
  assign ch_last   = (ch_cnt_q == ch_m1);

  assign ofm_valid = ofm_vld_q;
  assign ofm_data  = ofm_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  // Weight bank keeps its contents across reset and jobs.
  always_ff @(posedge clk) begin
    if (wgt_fire) begin
      wgt_bank[wgt_cnt_q[IDX_W-1:0]] <= wgt_data;
    end
  end

  logic [BW-1:0]          wrow;
  logic signed [PW-1:0]   a_x;
  logic signed [PW-1:0]   w_x;
  logic signed [PW-1:0]   prod;

  always_comb begin
    wrow   = wgt_bank[in_ch_q];
    psum_d = '0;
    a_x    = '0;
    w_x    = '0;
    prod   = '0;
    for (int i = 0; i < NE; i++) begin
      a_x    = {{DATA_W{in_data_q[i*DATA_W+DATA_W-1]}},
                in_data_q[i*DATA_W +: DATA_W]};
      w_x    = {{DATA_W{wrow[i*DATA_W+DATA_W-1]}},
                wrow[i*DATA_W +: DATA_W]};
      prod   = a_x * w_x;
      psum_d = psum_d + {{(ACC_W-PW){prod[PW-1]}}, prod};
    end
  end

  logic signed [RW-1:0] r0;
  logic signed [RW-1:0] rnd;
  logic signed [RW-1:0] r1;
  logic signed [RW-1:0] r2;
  logic [DATA_W-1:0]    sat;

  always_comb begin
    r0  = {{(RW-ACC_W){acc_q[ACC_W-1]}}, acc_q} +
          {{(RW-DATA_W){bias_q[DATA_W-1]}}, bias_q};
    rnd = (shift_q == 5'd0) ? '0 :
          ({{(RW-1){1'b0}}, 1'b1} << (shift_q - 5'd1));
    r1  = (r0 + rnd) >>> shift_q;
    r2  = (relu_q && r1[RW-1]) ? '0 : r1;
    if (r2 > SMAX) begin
      sat = SMAX[DATA_W-1:0];
    end else if (r2 < SMIN) begin
      sat = SMIN[DATA_W-1:0];
    end else begin
      sat = r2[DATA_W-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    num_ch_d   = num_ch_q;
    num_win_d  = num_win_q;
    bias_d     = bias_q;
    shift_d    = shift_q;
    relu_d     = relu_q;
    wgt_cnt_d  = wgt_cnt_q;
    ch_cnt_d   = ch_cnt_q;
    win_cnt_d  = win_cnt_q;
    drain_d    = drain_q;
    in_vld_d   = ifm_fire;
    in_data_d  = in_data_q;
    in_ch_d    = in_ch_q;
    in_last_d  = in_last_q;
    s1_vld_d   = in_vld_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    acc_d      = acc_q;
    fin_d      = fin_q;
    ofm_vld_d  = ofm_vld_q;
    ofm_d      = ofm_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && cfg_ok) begin
          num_ch_d  = cfg_num_ch;
          num_win_d = cfg_num_win;
          bias_d    = cfg_bias;
          shift_d   = cfg_shift;
          relu_d    = cfg_relu_en;
          wgt_cnt_d = '0;
          ch_cnt_d  = '0;
          win_cnt_d = '0;
          drain_d   = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (wgt_fire) begin
          if (wgt_cnt_q == ch_m1) begin
            wgt_cnt_d = '0;
            state_d   = S_COMP;
          end else begin
            wgt_cnt_d = wgt_cnt_q + 1'b1;
          end
        end
      end
      S_COMP: begin
        if (ofm_fire && (win_cnt_q == win_m1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (ifm_fire) begin
      in_data_d = ifm_data;
      in_ch_d   = ch_cnt_q[IDX_W-1:0];
      in_last_d = ch_last;
      if (ch_last) begin
        ch_cnt_d = '0;
        drain_d  = 1'b1;
      end else begin
        ch_cnt_d = ch_cnt_q + 1'b1;
      end
    end

    if (in_vld_q) begin
      s1_first_d = (in_ch_q == '0);
      s1_last_d  = in_last_q;
    end

    if (s1_vld_q) begin
      acc_d = (s1_first_q ? '0 : acc_q) + psum_q;
      if (s1_last_q) begin
        fin_d = 1'b1;
      end
    end

    // Load and handshake may coincide: the new result replaces the taken one.
    if (ofm_load) begin
      ofm_d     = sat;
      ofm_vld_d = 1'b1;
      fin_d     = 1'b0;
      drain_d   = 1'b0;
    end else if (ofm_fire) begin
      ofm_vld_d = 1'b0;
    end

    if (ofm_fire) begin
      win_cnt_d = win_cnt_q + 1'b1;
    end

    if (state_q == S_DONE) begin
      in_vld_d = 1'b0;
      s1_vld_d = 1'b0;
      fin_d    = 1'b0;
      drain_d  = 1'b0;
      ch_cnt_d = '0;
    end
  end

  logic signed [ACC_W-1:0] psum_n;
  assign psum_n = in_vld_q ? psum_d : psum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      num_ch_q   <= '0;
      num_win_q  <= '0;
      bias_q     <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      wgt_cnt_q  <= '0;
      ch_cnt_q   <= '0;
      win_cnt_q  <= '0;
      drain_q    <= 1'b0;
      in_vld_q   <= 1'b0;
      in_data_q  <= '0;
      in_ch_q    <= '0;
      in_last_q  <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      psum_q     <= '0;
      acc_q      <= '0;
      fin_q      <= 1'b0;
      ofm_vld_q  <= 1'b0;
      ofm_q      <= '0;
    end else begin
      state_q    <= state_d;
      num_ch_q   <= num_ch_d;
      num_win_q  <= num_win_d;
      bias_q     <= bias_d;
      shift_q    <= shift_d;
      relu_q     <= relu_d;
      wgt_cnt_q  <= wgt_cnt_d;
      ch_cnt_q   <= ch_cnt_d;
      win_cnt_q  <= win_cnt_d;
      drain_q    <= drain_d;
      in_vld_q   <= in_vld_d;
      in_data_q  <= in_data_d;
      in_ch_q    <= in_ch_d;
      in_last_q  <= in_last_d;
      s1_vld_q   <= s1_vld_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      psum_q     <= psum_n;
      acc_q      <= acc_d;
      fin_q      <= fin_d;
      ofm_vld_q  <= ofm_vld_d;
      ofm_q      <= ofm_d;
    end
  end

endmodule
